burst_pmem: RTL and testbench

BURST_PMEM -- requirements
Module: burst_pmem

---
 rtl/burst_pmem.sv | 122 ++++++++++++
 tb/tb_burst_pmem.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/burst_pmem.sv
// Fixed-latency line memory: one line read or written per request, resp LATENCY cycles after acceptance.
// Optional protocol checker enabled by defining BURST_PMEM_PROTOCOL_CHECK_EN (err tied low otherwise).
`timescale 1ns/1ps
module burst_pmem #(
  parameter  int ADDR_W   = 16,
  parameter  int LINE_W   = 128,
  parameter  int DEPTH    = 4096,
  parameter  int LATENCY  = 4,
  localparam int OFFSET   = $clog2(LINE_W/8),
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int LINE_A_W = ADDR_W - OFFSET
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [LINE_W-1:0]   wdata,
  output logic                resp,
  output logic [LINE_W-1:0]   rdata,
  output logic                mon_write,
  output logic [LINE_A_W-1:0] mon_addr,
  output logic [LINE_W-1:0]   mon_data,
  output logic                err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_cnt;
  logic                  r_wr;
  logic [LINE_A_W-1:0]   r_line;
  logic [LINE_W-1:0]     r_wdata;
  logic [LINE_W-1:0]     r_mem [DEPTH];

  logic                  w_req;
  logic                  w_accept;
  logic                  w_nxt_wr;
  logic [IDX_W-1:0]      w_nxt_idx;
  logic                  w_commit;
  logic                  w_unused_addr;

  assign w_req    = read | write;
  assign w_accept = (r_state == S_IDLE) && w_req;
  // The line bits below OFFSET only select bytes within a line.
  assign w_unused_addr = ^address[OFFSET-1:0];

  // Index/op of the transaction about to enter RESP; with LATENCY=1 it comes straight from the inputs.
  assign w_nxt_wr  = (r_state == S_IDLE) ? write : r_wr;
  assign w_nxt_idx = (r_state == S_IDLE) ? address[OFFSET+IDX_W-1:OFFSET] : r_line[IDX_W-1:0];

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
      S_BUSY:  if (r_cnt == 8'd1) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_line  <= '0;
      r_wdata <= '0;
      rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_wr    <= write;
        r_line  <= address[ADDR_W-1:OFFSET];
        r_wdata <= wdata;
        r_cnt   <= 8'(LATENCY - 1);
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if ((w_state_nxt == S_RESP) && !w_nxt_wr) rdata <= r_mem[w_nxt_idx];
    end
  end

  // NOTE: the array has no reset; an async reset on it would block RAM inference.
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[r_line[IDX_W-1:0]] <= r_wdata;
  end

  assign resp      = (r_state == S_RESP);
  assign w_commit  = resp && r_wr;
  assign mon_write = w_commit;
  assign mon_addr  = w_commit ? r_line  : '0;
  assign mon_data  = w_commit ? r_wdata : '0;

`ifdef BURST_PMEM_PROTOCOL_CHECK_EN
  logic r_err;
  logic w_proto_err;

  always_comb begin
    w_proto_err = 1'b0;
    if ((r_state == S_IDLE) && read && write) w_proto_err = 1'b1;
    if (r_state == S_BUSY) begin
      if (r_wr ? !write : !read)                   w_proto_err = 1'b1;
      if (address[ADDR_W-1:OFFSET] != r_line)      w_proto_err = 1'b1;
      if (r_wr && (wdata != r_wdata))              w_proto_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_err <= 1'b0;
    else if (w_proto_err) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_pmem.sv
// Directed bench for burst_pmem: main instance (DEPTH=16, LATENCY=4) and a LATENCY=1 instance.
`timescale 1ns/1ps
module tb_burst_pmem;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef BURST_PMEM_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  localparam logic [127:0] D_A5  = {16{8'hA5}};
  localparam logic [127:0] D_X   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D_BAD = {4{32'hDEAD_BEEF}};
  localparam logic [127:0] D_W   = 128'h5A5A_0000_1111_2222_3333_4444_5555_C3C3;
  localparam logic [127:0] D_CH  = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;

  // Main instance
  logic         a_read = 1'b0, a_write = 1'b0;
  logic [15:0]  a_address = '0;
  logic [127:0] a_wdata = '0;
  logic         a_resp, a_mon_write, a_err;
  logic [127:0] a_rdata, a_mon_data;
  logic [11:0]  a_mon_addr;

  // LATENCY=1 instance
  logic         b_read = 1'b0, b_write = 1'b0;
  logic [15:0]  b_address = '0;
  logic [127:0] b_wdata = '0;
  logic         b_resp, b_mon_write, b_err;
  logic [127:0] b_rdata, b_mon_data;
  logic [11:0]  b_mon_addr;

  burst_pmem #(.DEPTH(16), .LATENCY(4)) u_main (
    .clk(clk), .rst_n(rst_n), .read(a_read), .write(a_write), .address(a_address),
    .wdata(a_wdata), .resp(a_resp), .rdata(a_rdata), .mon_write(a_mon_write),
    .mon_addr(a_mon_addr), .mon_data(a_mon_data), .err(a_err)
  );

  burst_pmem #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .read(b_read), .write(b_write), .address(b_address),
    .wdata(b_wdata), .resp(b_resp), .rdata(b_rdata), .mon_write(b_mon_write),
    .mon_addr(b_mon_addr), .mon_data(b_mon_data), .err(b_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Result of the last transaction on the main instance, captured in its resp cycle.
  int           t_lat;
  logic         t_seen;
  logic [127:0] t_rdata, t_md;
  logic         t_mw;
  logic [11:0]  t_ma;

  task automatic wait_resp(input string tag);
    t_seen = 1'b0;
    t_lat  = 0;
    for (int i = 1; i <= 20 && !t_seen; i++) begin
      @(negedge clk);
      if (a_resp) begin
        t_seen  = 1'b1;
        t_lat   = i;
        t_rdata = a_rdata;
        t_mw    = a_mon_write;
        t_ma    = a_mon_addr;
        t_md    = a_mon_data;
      end
    end
    a_read  = 1'b0;
    a_write = 1'b0;
    check({tag, "_resp_seen"}, 128'(t_seen), 128'd1);
  endtask

  task automatic txn(input string tag, input logic rd, input logic wr,
                     input logic [15:0] addr, input logic [127:0] data);
    @(negedge clk);
    a_read    = rd;
    a_write   = wr;
    a_address = addr;
    a_wdata   = data;
    wait_resp(tag);
  endtask

  initial begin
    logic bad;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_resp",      128'(a_resp),      128'd0);
    check("rst_rdata",     a_rdata,           128'd0);
    check("rst_mon_write", 128'(a_mon_write), 128'd0);
    check("rst_mon_addr",  128'(a_mon_addr),  128'd0);
    check("rst_mon_data",  a_mon_data,        128'd0);
    check("rst_err",       128'(a_err),       128'd0);
    check("rst_b_resp",    128'(b_resp),      128'd0);
    rst_n = 1'b1;

    // Write 0x0120, then read 0x012F (same line, low bits ignored)
    txn("wr0120", 1'b0, 1'b1, 16'h0120, D_A5);
    check("wr0120_lat",      128'(t_lat), 128'd4);
    check("wr0120_mon_wr",   128'(t_mw),  128'd1);
    check("wr0120_mon_addr", 128'(t_ma),  128'h012);
    check("wr0120_mon_data", t_md,        D_A5);
    txn("rd012F", 1'b1, 1'b0, 16'h012F, '0);
    check("rd012F_lat",      128'(t_lat), 128'd4);
    check("rd012F_rdata",    t_rdata,     D_A5);
    check("rd012F_mon_wr",   128'(t_mw),  128'd0);
    check("rd012F_mon_addr", 128'(t_ma),  128'd0);
    check("rd012F_mon_data", t_md,        128'd0);
    @(negedge clk);
    check("rd012F_resp_fell", 128'(a_resp), 128'd0);
    check("rd012F_rdata_hold", a_rdata,     D_A5);

    // Aliasing: 0x0010 and 0x0110 share index 1 when DEPTH=16
    txn("wr0010", 1'b0, 1'b1, 16'h0010, D_X);
    check("wr0010_mon_addr", 128'(t_ma), 128'h001);
    txn("rd0110", 1'b1, 1'b0, 16'h0110, '0);
    check("rd0110_alias", t_rdata, D_X);

    // Reset two cycles into a write aborts it
    txn("wr0300_zero", 1'b0, 1'b1, 16'h0300, '0);
    @(negedge clk);
    a_write = 1'b1; a_address = 16'h0300; a_wdata = D_BAD;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bad = bad | a_resp | a_mon_write;
    end
    a_write = 1'b0;
    rst_n   = 1'b1;
    check("abort_no_resp", 128'(bad), 128'd0);
    txn("rd0300", 1'b1, 1'b0, 16'h0300, '0);
    check("rd0300_after_abort", t_rdata, 128'd0);
    check("err_before_both", 128'(a_err), 128'd0);

    // Read and write both high: treated as a write
    txn("both0040", 1'b1, 1'b1, 16'h0040, D_W);
    check("both_lat",      128'(t_lat), 128'd4);
    check("both_mon_wr",   128'(t_mw),  128'd1);
    check("both_mon_addr", 128'(t_ma),  128'h004);
    check("both_mon_data", t_md,        D_W);
    @(negedge clk);
    check("both_err", 128'(a_err), 128'(EXP_ERR));
    txn("rd0040", 1'b1, 1'b0, 16'h0040, '0);
    check("rd0040_rdata", t_rdata, D_W);

    // Address/data changed mid-transaction: latched values win
    @(negedge clk);
    a_write = 1'b1; a_address = 16'h0050; a_wdata = D_X;
    @(negedge clk);
    a_address = 16'h0070; a_wdata = D_CH;
    wait_resp("chg0050");
    check("chg_mon_addr", 128'(t_ma), 128'h005);
    check("chg_mon_data", t_md,       D_X);
    txn("rd0050", 1'b1, 1'b0, 16'h0050, '0);
    check("rd0050_rdata", t_rdata, D_X);
    check("chg_err", 128'(a_err), 128'(EXP_ERR));

    // Reset clears the sticky error
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("err_cleared", 128'(a_err), 128'd0);
    rst_n = 1'b1;

    // LATENCY=1 with read held: resp every second cycle
    @(negedge clk);
    b_read = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("lat1_resp_%0d", k), 128'(b_resp), 128'(k % 2));
    end
    b_read = 1'b0;
    check("lat1_err", 128'(b_err), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
